pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the PC, IF/ID and ID/EX register enables. It detects RAW hazards against instructions in EX and MEM and stalls for the required number of cycles, since the core has no forwarding. It also flushes wrong-path instructions on a taken branch or jump, and supports a board-driven single-step mode. It sits beside the ID stage; its `id_ex_en` output feeds the ID/EX register's `Enable` input, where low loads a bubble.

## Interface
- `CNT_W`, default 16: width of the saturating performance counters.
- `clk` input 1: pipeline clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `id_rs` input 5: rs field of the instruction in ID.
- `id_rt` input 5: rt field of the instruction in ID.
- `id_uses_rt` input 1: ID instruction reads rt (R-type, store, beq/bne).
- `ex_wdst` input 5: final write register of the EX instruction (after RegDst/Jal mux).
- `ex_RegWrite` input 1: EX instruction writes the register file.
- `mem_wdst` input 5: write register of the MEM instruction.
- `mem_RegWrite` input 1: MEM instruction writes the register file.
- `ex_branch_taken` input 1: branch or jump resolved taken in EX this cycle.
- `step_mode` input 1: single-step enable (board switch, quasi-static).
- `step_btn` input 1: step button, asynchronous and debounced upstream.
- `cnt_clr` input 1: synchronous clear of both counters.
- `pc_en` output 1: PC load enable.
- `if_id_en` output 1: IF/ID load enable.
- `if_id_flush` output 1: IF/ID loads a NOP.
- `id_ex_en` output 1: ID/EX Enable; 0 inserts a bubble.
- `stall_cnt` output CNT_W: count of cycles lost to RAW stalls.
- `flush_cnt` output CNT_W: count of taken-branch flushes.

## Operation
- **Hazard terms**
  - `hz_ex` = ex_RegWrite and ex_wdst≠0 and (ex_wdst==id_rs, or id_uses_rt and ex_wdst==id_rt).
  - `hz_mem` is the same test using the mem_* inputs.
  - Register $0 never causes a hazard.
- **Stall lengths**
  - The register file writes in the first half-cycle, so a WB writer needs no stall.
  - `hz_ex` needs 2 stall cycles. `hz_mem` alone needs 1.
- **FSM states:** RUN, STALL, STEP_WAIT. There is a 2-bit remaining-stall counter `rem`.
- **RUN**
  - If ex_branch_taken: flush (see below) and stay in RUN.
  - Else if hz_ex: stall this cycle, then go to STALL with rem=1.
  - Else if hz_mem: stall this cycle and stay in RUN. Re-evaluation next cycle finds no hazard.
  - Else: normal issue with pc_en=if_id_en=id_ex_en=1. If step_mode=1, go to STEP_WAIT.
- **STALL**
  - Stall outputs while rem>0, decrementing rem.
  - At rem==0, return to RUN and re-evaluate hazards in that same cycle.
  - A taken branch in STALL aborts the stall: flush, go to RUN, rem=0.
- **STEP_WAIT**
  - Outputs: pc_en=if_id_en=0, id_ex_en=0. The in-flight instructions drain while bubbles are injected.
  - On a synchronized step_btn rising edge, go to RUN.
  - If step_mode drops, go to RUN immediately.
  - A taken branch reaching EX while in STEP_WAIT is flushed; state is unchanged.
- **Stall outputs:** pc_en=0, if_id_en=0, if_id_flush=0, id_ex_en=0.
- **Flush outputs:** pc_en=1 (PC takes the target through the external mux), if_id_en=1, if_id_flush=1, id_ex_en=0.
- **Priority:** reset > flush > RAW stall > step gating.
- **Counters**
  - stall_cnt increments in every cycle with stall outputs.
  - flush_cnt increments in every flush cycle.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment.

## Timing
- Enables and flush are combinational from state plus the current-cycle inputs. Effect is same-cycle; the pipeline registers sample them at the next edge.
- State, rem, the step synchronizer (2 flops plus an edge flop) and the counters are registered.
- Step latency: button edge → RUN two to three cycles later → exactly one instruction issued per press.
- **During rst:** state=RUN, rem=0, counters=0, synchronizer=0.
  - Outputs during rst: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_en=0, so ID/EX holds a bubble.
- **First cycle after deassert:** normal RUN evaluation.
- Reset asserted mid-stall or mid-step takes effect immediately (asynchronous).
- When hz_ex and hz_mem are both true, the stall length is 2 (hz_ex wins).

## Structure
- Package `mips_pipe_pkg` holds:
  - the state enum (RUN, STALL, STEP_WAIT);
  - the constants STALL_EX=2 and STALL_MEM=1;
  - the $0 register constant.
- Sub-module `hazard_cmp` is combinational and instantiated twice, once for EX and once for MEM.
  - Inputs: rs, rt, uses_rt, wdst, regwrite.
  - Output: hit.
- The FSM, synchronizer and counters live in the top level.

## Test plan
- **add r3 in EX, dependent add r4,r3,r1 in ID:**
  - 2 consecutive cycles with pc_en=if_id_en=id_ex_en=0;
  - third cycle all enables 1;
  - stall_cnt=2.
- **Writer r5 in MEM only, ID reads r5 via rt with id_uses_rt=1:**
  - exactly 1 stall cycle.
  - Repeat with id_uses_rt=0: no stall.
- **ex_wdst=0 with ex_RegWrite=1, id_rs=0:** no stall.
- **ex_branch_taken=1 in the same cycle as hz_ex:**
  - if_id_flush=1, id_ex_en=0, pc_en=1;
  - no subsequent stall cycle;
  - flush_cnt=1.
- **step_mode=1:**
  - one issue cycle, then enables stay low for 20 cycles;
  - a step_btn pulse yields exactly one more id_ex_en=1 cycle two to three cycles later.
- **rst asserted in STALL with rem=1:**
  - outputs go to reset values immediately;
  - after release, RUN with counters 0.
- **Preload stall_cnt to all-ones** (CNT_W=4, 15 stalls), then another stall: value stays 15. cnt_clr → 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline sequencing controller.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STALL     = 2'd1,
    STEP_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] STALL_EX  = 2'd2;
  localparam logic [1:0] STALL_MEM = 2'd1;
  localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM register fields in, pipeline enables and counters out.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_wdst;
  logic             ex_RegWrite;
  logic [4:0]       mem_wdst;
  logic             mem_RegWrite;
  logic             ex_branch_taken;
  logic             step_mode;
  logic             step_btn;
  logic             cnt_clr;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_wdst, ex_RegWrite, mem_wdst, mem_RegWrite,
           ex_branch_taken, step_mode, step_btn, cnt_clr,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_wdst, ex_RegWrite, mem_wdst, mem_RegWrite,
           ex_branch_taken, step_mode, step_btn, cnt_clr,
    output pc_en, if_id_en, if_id_flush, id_ex_en, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// RAW comparator: does a downstream writer target a register the ID instruction reads?
module hazard_cmp
  import mips_pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  input  logic [4:0] wdst,
  input  logic       regwrite,
  output logic       hit
);

  // $0 is hardwired to zero, so writes to it never create a dependency.
  assign hit = regwrite && (wdst != REG_ZERO) &&
               ((wdst == rs) || (uses_rt && (wdst == rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/single-step sequencing for a forwarding-less 5-stage MIPS pipeline.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state, state_nx;
  logic [1:0]       rem, rem_nx;
  logic             btn_s1, btn_s2, btn_s3;
  logic             step_rise;
  logic             hit_ex, hit_mem;
  logic             eff_run;
  logic             stall_act, flush_act;
  logic [CNT_W-1:0] stall_q, flush_q;

  hazard_cmp u_cmp_ex (
    .rs(bus.id_rs), .rt(bus.id_rt), .uses_rt(bus.id_uses_rt),
    .wdst(bus.ex_wdst), .regwrite(bus.ex_RegWrite), .hit(hit_ex)
  );

  hazard_cmp u_cmp_mem (
    .rs(bus.id_rs), .rt(bus.id_rt), .uses_rt(bus.id_uses_rt),
    .wdst(bus.mem_wdst), .regwrite(bus.mem_RegWrite), .hit(hit_mem)
  );

  assign step_rise = btn_s2 & ~btn_s3;
  // STALL with nothing left behaves exactly like RUN in the same cycle.
  assign eff_run   = (state == RUN) || ((state == STALL) && (rem == 2'd0));

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.if_id_en    = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_en    = 1'b0;
    state_nx        = state;
    rem_nx          = rem;
    stall_act       = 1'b0;
    flush_act       = 1'b0;
    if (rst) begin
      state_nx = RUN;
      rem_nx   = 2'd0;
    end else if (bus.ex_branch_taken) begin
      bus.pc_en       = 1'b1;
      bus.if_id_en    = 1'b1;
      bus.if_id_flush = 1'b1;
      flush_act       = 1'b1;
      rem_nx          = 2'd0;
      state_nx        = (state == STEP_WAIT) ? STEP_WAIT : RUN;
    end else if (eff_run) begin
      if (hit_ex) begin
        stall_act = 1'b1;
        state_nx  = STALL;
        rem_nx    = STALL_EX - 2'd1;
      end else if (hit_mem) begin
        stall_act = 1'b1;
        state_nx  = RUN;
        rem_nx    = STALL_MEM - 2'd1;
      end else begin
        bus.pc_en    = 1'b1;
        bus.if_id_en = 1'b1;
        bus.id_ex_en = 1'b1;
        rem_nx       = 2'd0;
        state_nx     = bus.step_mode ? STEP_WAIT : RUN;
      end
    end else begin
      case (state)
        STALL: begin
          stall_act = 1'b1;
          rem_nx    = rem - 2'd1;
        end
        STEP_WAIT: begin
          if (!bus.step_mode || step_rise) begin
            state_nx = RUN;
          end else begin
            state_nx = STEP_WAIT;
          end
        end
        default: begin
          state_nx = RUN;
          rem_nx   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  // The step button is asynchronous: two flops to resolve metastability, one to find the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      btn_s1 <= bus.step_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_act && (stall_q != CNT_MAX)) stall_q <= stall_q + 1'b1;
      if (flush_act && (flush_q != CNT_MAX)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule
